uart_receive: RTL and testbench
===============================

// Module: uart_receive
// PURPOSE
//  UART receive path pairing with the team's UART transmitter: recovers idle-high, start(0)/data LSB-first/stop(1) frames from a serial line.
//  Synchronises rx, mid-bit samples at CLKS_PER_BIT clocks per bit, checks the stop bit, delivers words over a valid/ready holding register.
//  CLKS_PER_BIT=1 accepts the transmitter's one-bit-per-clock stream directly (loopback in the UART subsystem).
// PARAMETERS
//  D_WIDTH       11  data bits per frame (matches transmitter)
//  CLKS_PER_BIT   1  clocks per serial bit; >=1
//  SYNC_STAGES    2  rx synchroniser flops; >=1
// PORTS
//  clk          in   1        single clock; all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  rx           in   1        serial line, idle high
//  rx_ready     in   1        consumer accepts rx_data when rx_valid&rx_ready
//  rx_data      out  D_WIDTH  received word, stable while rx_valid
//  rx_valid     out  1        word available; held until accepted
//  rx_busy      out  1        high in START/DATA/STOP
//  frame_err    out  1        1-cycle pulse: stop bit sampled 0
//  overrun      out  1        1-cycle pulse: frame completed while holding reg full and not accepted
// BEHAVIOUR
//  Reset: synchroniser flops=1, state=IDLE, rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0. Reset mid-frame aborts it, no flag.
//  rx_s = rx after SYNC_STAGES flops. HALF=CLKS_PER_BIT/2 (integer). cnt width $clog2(CLKS_PER_BIT+1), bit index $clog2(D_WIDTH+1).
//  IDLE: rx_s==0 -> if HALF==0: DATA, cnt=CLKS_PER_BIT-1, idx=0; else START, cnt=HALF-1.
//  START: cnt!=0 -> cnt--. cnt==0: rx_s==0 -> DATA, cnt=CLKS_PER_BIT-1, idx=0; rx_s==1 -> IDLE (glitch rejected, no flag).
//  DATA: cnt!=0 -> cnt--. cnt==0: shift_reg={rx_s,shift_reg[D_WIDTH-1:1]} (LSB first), cnt reload, idx++; after D_WIDTH-th bit -> STOP.
//  STOP: cnt!=0 -> cnt--. cnt==0: rx_s==1 -> deliver, IDLE; rx_s==0 -> frame_err pulse, word dropped, WAIT_IDLE.
//  WAIT_IDLE: stay until rx_s==1, then IDLE (no false start on a held-low/break line).
//  Stop sample at clock k+HALF+(D_WIDTH+1)*CLKS_PER_BIT, k = first cycle rx_s==0; rx_valid visible the following cycle.
//   CLKS_PER_BIT=1, SYNC_STAGES=2: rx_valid rises 15 clocks after the rx start-bit edge.
//  Deliver: rx_valid==0, or rx_valid&rx_ready same cycle -> rx_data=shift_reg, rx_valid=1 (accept and reload coincide: new word wins, valid stays 1).
//   rx_valid&!rx_ready -> overrun pulse, new word dropped, old rx_data/rx_valid kept.
//  rx_valid&rx_ready with no delivery -> rx_valid=0 next cycle; rx_data holds last value.
//  Back-to-back frames: returns to IDLE the cycle after stop sample; next start may follow immediately.
//  frame_err and overrun are mutually exclusive; both registered, never high two consecutive cycles for one frame.
// STRUCTURE
//  uart_pkg: rx state enum (IDLE,START,DATA,STOP,WAIT_IDLE), default D_WIDTH/CLKS_PER_BIT, frame constants (START_BIT=0, STOP_BIT=1); shared with transmitter.
//  Sub-module uart_rx_sync: SYNC_STAGES-deep reset-to-1 synchroniser; everything else in one FSM + datapath.
// TESTING (D_WIDTH=11, SYNC_STAGES=2 unless stated)
//  1 CPB=1, rx_ready=1, transmitter loopback sends 11'h5A3 -> rx_data=11'h5A3, rx_valid 1 cycle, 15 clocks after start edge, no flags.
//  2 CPB=1, frame 11'h7FF with stop bit forced 0, line held low 5 cycles -> frame_err 1 cycle, no rx_valid, WAIT_IDLE until rx=1; next frame 11'h001 received.
//  3 CPB=4, rx low 1 clock then high -> START rejects at mid-sample, no rx_valid/frame_err, back in IDLE; following valid frame 11'h2AA received.
//  4 CPB=1, rx_ready=0, frames 11'h123 then 11'h456 -> rx_data=11'h123 held, overrun pulse at 2nd stop; raise rx_ready -> rx_valid drops next cycle.
//  5 rst asserted mid-DATA of 11'h3C3 -> all outputs reset next cycle, no rx_valid for that frame; next frame 11'h0F0 received intact.
//  6 CPB=1, three consecutive transmitter frames, rx_ready=1 -> three rx_valid pulses, data in order, no flags; rx_busy low between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding, default frame
// geometry and line-level bit values, shared with the transmitter.
package uart_pkg;

  localparam int D_WIDTH_DEF      = 11;
  localparam int CLKS_PER_BIT_DEF = 1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Reset-to-1 (idle line) synchroniser for the serial input.
// Ports: clk, rst (sync, active high), rx_i (async line), rx_s_o.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  generate
    if (SYNC_STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= rx_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      end
    end
  endgenerate

  assign rx_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receive.sv
// UART receiver: mid-bit sampling of start/data(LSB first)/stop frames,
// stop-bit check and a valid/ready holding register for the word.
// Ports: clk, rst (sync, active high), rx, rx_ready in;
//        rx_data, rx_valid, rx_busy, frame_err, overrun out.
module uart_receive
  import uart_pkg::*;
#(
  parameter int D_WIDTH      = D_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rx_ready,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               frame_err,
  output logic               overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int IW   = $clog2(D_WIDTH + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(D_WIDTH - 1);

  logic rx_s;

  rx_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idx_q;
  logic [D_WIDTH-1:0] shift_q;
  logic [D_WIDTH-1:0] data_q;
  logic               valid_q;
  logic               busy_q;
  logic               ferr_q;
  logic               ovr_q;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_i  (rx),
    .rx_s_o(rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && rx_ready) valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_s == START_BIT) begin
            busy_q <= 1'b1;
            // With one clock per bit there is no half-bit to wait:
            // the start edge itself is the start-bit sample.
            if (HALF == 0) begin
              state_q <= DATA;
              cnt_q   <= CNT_FULL;
              idx_q   <= '0;
            end else begin
              state_q <= START;
              cnt_q   <= CNT_HALF;
            end
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (rx_s == START_BIT) begin
            state_q <= DATA;
            cnt_q   <= CNT_FULL;
            idx_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {rx_s, shift_q[D_WIDTH-1:1]};
            cnt_q   <= CNT_FULL;
            idx_q   <= idx_q + IW'(1);
            if (idx_q == IDX_LAST) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            busy_q <= 1'b0;
            if (rx_s == STOP_BIT) begin
              state_q <= IDLE;
              // A same-cycle accept frees the holding register.
              if (!valid_q || rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s == STOP_BIT) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: CLKS_PER_BIT=1 and =4 instances
// driven with hand-built frames on a shared clock and reset.
module tb_uart_receive;

  logic clk = 1'b0;
  logic rst;
  logic rx1, rdy1, rx4, rdy4;

  logic [10:0] data1, data4;
  logic valid1, busy1, fe1, ov1;
  logic valid4, busy4, fe4, ov4;

  int checks = 0;
  int errors = 0;

  logic [10:0] q1[$];
  logic [10:0] q4[$];
  int fe_cnt1 = 0, ov_cnt1 = 0;
  int fe_cnt4 = 0;

  always #5 clk = ~clk;

  uart_receive #(
    .D_WIDTH(11), .CLKS_PER_BIT(1), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_ready(rdy1),
    .rx_data(data1), .rx_valid(valid1), .rx_busy(busy1),
    .frame_err(fe1), .overrun(ov1)
  );

  uart_receive #(
    .D_WIDTH(11), .CLKS_PER_BIT(4), .SYNC_STAGES(2)
  ) dut4 (
    .clk(clk), .rst(rst), .rx(rx4), .rx_ready(rdy4),
    .rx_data(data4), .rx_valid(valid4), .rx_busy(busy4),
    .frame_err(fe4), .overrun(ov4)
  );

  always @(negedge clk) begin
    if (valid1 && rdy1) q1.push_back(data1);
    if (valid4 && rdy4) q4.push_back(data4);
    if (fe1) fe_cnt1++;
    if (ov1) ov_cnt1++;
    if (fe4) fe_cnt4++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start, 11 data bits LSB first, stop; line left at the stop value
  task automatic send1(input logic [10:0] d, input logic stopb);
    rx1 = 1'b0;
    tick(1);
    for (int i = 0; i < 11; i++) begin
      rx1 = d[i];
      tick(1);
    end
    rx1 = stopb;
    tick(1);
  endtask

  task automatic send4(input logic [10:0] d);
    rx4 = 1'b0;
    tick(4);
    for (int i = 0; i < 11; i++) begin
      rx4 = d[i];
      tick(4);
    end
    rx4 = 1'b1;
    tick(4);
  endtask

  logic [12:0] frm [0:2];
  logic [12:0] cur;
  int qn;
  int fe0, ov0;

  initial begin
    rst = 1'b1; rx1 = 1'b1; rx4 = 1'b1;
    rdy1 = 1'b1; rdy4 = 1'b1;
    tick(3);

    chk("rst_valid", {31'd0, valid1}, 32'd0);
    chk("rst_data", {21'd0, data1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_ferr", {31'd0, fe1}, 32'd0);
    chk("rst_ovr", {31'd0, ov1}, 32'd0);
    chk("rst_valid4", {31'd0, valid4}, 32'd0);
    rst = 1'b0;
    tick(3);

    // 1: loopback word, rx_valid 15 clocks after start edge
    send1(11'h5A3, 1'b1);
    chk("t1_busy13", {31'd0, busy1}, 32'd1);
    tick(1);
    chk("t1_valid14", {31'd0, valid1}, 32'd0);
    tick(1);
    chk("t1_valid15", {31'd0, valid1}, 32'd1);
    chk("t1_data", {21'd0, data1}, 32'h5A3);
    chk("t1_busy15", {31'd0, busy1}, 32'd0);
    tick(1);
    chk("t1_pulse", {31'd0, valid1}, 32'd0);
    chk("t1_flags", fe_cnt1 + ov_cnt1, 32'd0);

    // 2: bad stop bit, line held low, then a good frame
    qn = q1.size();
    send1(11'h7FF, 1'b0);
    tick(2);
    chk("t2_ferr", {31'd0, fe1}, 32'd1);
    chk("t2_novalid", {31'd0, valid1}, 32'd0);
    tick(1);
    chk("t2_ferr_end", {31'd0, fe1}, 32'd0);
    chk("t2_nobusy", {31'd0, busy1}, 32'd0);
    tick(2);
    chk("t2_hold_busy", {31'd0, busy1}, 32'd0);
    rx1 = 1'b1;
    tick(4);
    chk("t2_fe_cnt", fe_cnt1, 32'd1);
    chk("t2_nodeliver", q1.size(), qn);
    send1(11'h001, 1'b1);
    tick(2);
    chk("t2_valid", {31'd0, valid1}, 32'd1);
    chk("t2_data", {21'd0, data1}, 32'h001);
    tick(2);

    // 3: one-clock glitch on CPB=4 line is rejected at mid-sample
    rx4 = 1'b0;
    tick(1);
    rx4 = 1'b1;
    tick(2);
    chk("t3_busy", {31'd0, busy4}, 32'd1);
    tick(2);
    chk("t3_idle", {31'd0, busy4}, 32'd0);
    tick(6);
    chk("t3_noflag", fe_cnt4, 32'd0);
    chk("t3_noword", q4.size(), 32'd0);
    send4(11'h2AA);
    tick(1);
    chk("t3_valid", {31'd0, valid4}, 32'd1);
    chk("t3_data", {21'd0, data4}, 32'h2AA);
    tick(2);
    chk("t3_count", q4.size(), 32'd1);
    chk("t3_fe_cnt", fe_cnt4, 32'd0);

    // 4: overrun with consumer stalled
    rdy1 = 1'b0;
    send1(11'h123, 1'b1);
    send1(11'h456, 1'b1);
    tick(2);
    chk("t4_ovr", {31'd0, ov1}, 32'd1);
    chk("t4_valid", {31'd0, valid1}, 32'd1);
    chk("t4_data", {21'd0, data1}, 32'h123);
    tick(1);
    chk("t4_ovr_end", {31'd0, ov1}, 32'd0);
    chk("t4_ov_cnt", ov_cnt1, 32'd1);
    rdy1 = 1'b1;
    tick(1);
    chk("t4_drop", {31'd0, valid1}, 32'd0);
    chk("t4_hold", {21'd0, data1}, 32'h123);

    // 5: reset in the middle of the data bits
    qn = q1.size();
    rx1 = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      rx1 = (11'h3C3 >> i) & 11'h1;
      tick(1);
    end
    chk("t5_busy", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    rx1 = 1'b1;
    tick(1);
    chk("t5_busy_rst", {31'd0, busy1}, 32'd0);
    chk("t5_data_rst", {21'd0, data1}, 32'd0);
    chk("t5_valid_rst", {31'd0, valid1}, 32'd0);
    rst = 1'b0;
    tick(15);
    chk("t5_noword", q1.size(), qn);
    send1(11'h0F0, 1'b1);
    tick(2);
    chk("t5_valid", {31'd0, valid1}, 32'd1);
    chk("t5_data", {21'd0, data1}, 32'h0F0);
    tick(2);

    // 6: three back-to-back frames
    q1.delete();
    fe0 = fe_cnt1;
    ov0 = ov_cnt1;
    frm[0] = {1'b1, 11'h1A5, 1'b0};
    frm[1] = {1'b1, 11'h24B, 1'b0};
    frm[2] = {1'b1, 11'h7E0, 1'b0};
    for (int j = 0; j < 39; j++) begin
      cur = frm[j / 13];
      rx1 = cur[j % 13];
      tick(1);
      if (j + 1 == 15 || j + 1 == 28)
        chk("t6_gap", {31'd0, busy1}, 32'd0);
      if (j + 1 == 16 || j + 1 == 29)
        chk("t6_rebusy", {31'd0, busy1}, 32'd1);
    end
    rx1 = 1'b1;
    tick(4);
    chk("t6_count", q1.size(), 32'd3);
    if (q1.size() == 3) begin
      chk("t6_w0", {21'd0, q1[0]}, 32'h1A5);
      chk("t6_w1", {21'd0, q1[1]}, 32'h24B);
      chk("t6_w2", {21'd0, q1[2]}, 32'h7E0);
    end
    chk("t6_flags", (fe_cnt1 - fe0) + (ov_cnt1 - ov0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
